// File: rtl/ad5302_dac_ctrl.sv
// ============================================================================
// Module      : ad5302_dac_ctrl
// Description : AD5302 dual-DAC frame sequencer in front of spi_master_core.
//               Round-robin arbitration between two channels, plus a GAP phase
//               that keeps CS high between frames and an ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ad5302_dac_ctrl #(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 65535,
  parameter int CS_INDEX   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_clk_div,
  input  logic        cfg_buf,
  input  logic [1:0]  cfg_pd,
  input  logic        a_valid,
  input  logic [7:0]  a_data,
  input  logic        b_valid,
  input  logic [7:0]  b_data,
  output logic [15:0] spi_clk_div,
  output logic [7:0]  spi_channel,
  output logic        spi_cpol,
  output logic        spi_cpha,
  output logic        spi_wr_req,
  input  logic        spi_wr_ack,
  output logic [15:0] spi_data,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clr_err,
  output logic [15:0] frame_cnt
);

  // One counter serves both the ack timeout and the gap, so size it for the larger.
  localparam int c_CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]         c_CHANNEL  = 8'(1) << CS_INDEX;
  localparam logic               c_CH_A     = 1'b0;
  localparam logic               c_CH_B     = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_pend_a;
  logic                 r_pend_b;
  logic [7:0]           r_code_a;
  logic [7:0]           r_code_b;
  logic                 r_last_grant;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_wr_req;
  logic [15:0]          r_data;
  logic                 r_timeout_err;
  logic [15:0]          r_frame_cnt;

  logic                 w_grant_any;
  logic                 w_grant_b;
  logic [7:0]           w_code;

  // B wins when it is the only requester, or when both wait and A went last.
  assign w_grant_any = r_pend_a | r_pend_b;
  assign w_grant_b   = r_pend_b & (~r_pend_a | (r_last_grant == c_CH_A));
  assign w_code      = w_grant_b ? r_code_b : r_code_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pend_a      <= 1'b0;
      r_pend_b      <= 1'b0;
      r_code_a      <= 8'h00;
      r_code_b      <= 8'h00;
      r_last_grant  <= c_CH_B;
      r_cnt         <= '0;
      r_wr_req      <= 1'b0;
      r_data        <= 16'h0000;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= 16'h0000;
    end else begin
      r_wr_req <= 1'b0;
      if (a_valid) begin
        r_code_a <= a_data;
        r_pend_a <= 1'b1;
      end
      if (b_valid) begin
        r_code_b <= b_data;
        r_pend_b <= 1'b1;
      end
      if (clr_err) begin
        r_timeout_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_data       <= {w_grant_b, cfg_buf, cfg_pd, w_code, 4'b0000};
            r_last_grant <= w_grant_b;
            // A code arriving on the grant cycle must stay pending for the next frame.
            if (w_grant_b) begin
              r_pend_b <= b_valid;
            end else begin
              r_pend_a <= a_valid;
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wr_req <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (spi_wr_ack) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_cnt       <= '0;
            r_state     <= S_GAP;
          end else if (r_cnt == c_TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign spi_clk_div = cfg_clk_div;
  assign spi_channel = c_CHANNEL;
  assign spi_cpol    = 1'b0;
  assign spi_cpha    = 1'b1;
  assign spi_wr_req  = r_wr_req;
  assign spi_data    = r_data;
  assign timeout_err = r_timeout_err;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != S_IDLE) | r_pend_a | r_pend_b;

endmodule

`default_nettype wire

// File: tb/tb_ad5302_dac_ctrl.sv
// ============================================================================
// Module      : tb_ad5302_dac_ctrl
// Description : Scoreboard bench for ad5302_dac_ctrl against a transaction-level
//               timeline model of arbitration, ack/timeout and gap timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ad5302_dac_ctrl;

  localparam int GAP = 5;
  localparam int TMO = 16;
  localparam int CSI = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_clk_div = 16'h0004;
  logic        cfg_buf = 1'b0;
  logic [1:0]  cfg_pd = 2'b00;
  logic        a_valid = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic        b_valid = 1'b0;
  logic [7:0]  b_data = 8'h00;
  logic [15:0] spi_clk_div;
  logic [7:0]  spi_channel;
  logic        spi_cpol;
  logic        spi_cpha;
  logic        spi_wr_req;
  logic        spi_wr_ack = 1'b0;
  logic [15:0] spi_data;
  logic        busy;
  logic        timeout_err;
  logic        clr_err = 1'b0;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  ad5302_dac_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .CS_INDEX(CSI)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_clk_div(cfg_clk_div), .cfg_buf(cfg_buf),
    .cfg_pd(cfg_pd), .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid),
    .b_data(b_data), .spi_clk_div(spi_clk_div), .spi_channel(spi_channel),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_wr_req(spi_wr_req),
    .spi_wr_ack(spi_wr_ack), .spi_data(spi_data), .busy(busy),
    .timeout_err(timeout_err), .clr_err(clr_err), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [15:0] word;
    int          edge_no;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Model: pending codes, last served channel, and the timeline of the current frame.
  bit          m_pend[2];
  logic [7:0]  m_code[2];
  int          m_last;
  int          idle_edge, ack_edge, to_edge, gap_lo, gap_hi;
  int          edge_n;
  logic [15:0] exp_frames;
  logic        exp_err;
  int          ack_mode;
  int          fixed_k;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
  endfunction

  task automatic model_reset();
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_code[0] = 8'h00; m_code[1] = 8'h00;
    m_last = 1;
    idle_edge = 0; ack_edge = -1; to_edge = -1; gap_lo = -1; gap_hi = -1;
    exp_frames = 16'h0000; exp_err = 1'b0;
  endtask

  // Present inputs for the next rising edge, advance the model over that edge, then check status.
  task automatic step(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd,
                      input bit clr, input bit late_ok);
    int  e, ch, k, done;
    bit  busy_exp;
    e = edge_n + 1;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; clr_err = clr;
    spi_wr_ack = (e == ack_edge) ||
                 (late_ok && e > gap_lo && e <= gap_hi && $urandom_range(0, 2) == 0);

    if (e == ack_edge) exp_frames = exp_frames + 16'd1;
    if (e == to_edge) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;

    if (e >= idle_edge && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) ch = 1 - m_last;
      else ch = m_pend[1] ? 1 : 0;
      exp_q.push_back('{word: {(ch == 1), cfg_buf, cfg_pd, m_code[ch], 4'h0}, edge_no: e + 1});
      m_pend[ch] = 1'b0;
      m_last = ch;
      if (ack_mode == 1 || (ack_mode == 0 && $urandom_range(0, 5) == 0)) begin
        ack_edge = -1;
        to_edge = e + 1 + TMO;
        done = to_edge;
      end else begin
        k = (ack_mode == 2) ? fixed_k : int'($urandom_range(1, TMO - 1));
        ack_edge = e + 1 + k;
        to_edge = -1;
        done = ack_edge;
      end
      gap_lo = done; gap_hi = done + GAP; idle_edge = done + GAP + 1;
    end
    if (av) begin m_code[0] = ad; m_pend[0] = 1'b1; end
    if (bv) begin m_code[1] = bd; m_pend[1] = 1'b1; end

    @(posedge clk);
    edge_n++;
    #1;
    busy_exp = m_pend[0] || m_pend[1] || (edge_n < idle_edge - 1);
    check("frame_cnt", frame_cnt, exp_frames);
    check("timeout_err", timeout_err, exp_err);
    check("busy", busy, busy_exp);
    check("spi_clk_div", spi_clk_div, cfg_clk_div);
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((edge_n < idle_edge || m_pend[0] || m_pend[1]) && guard < 200) begin
      idle_step();
      guard++;
    end
    if (guard >= 200) check("drain_bound", guard, 0);
    idle_step();
    idle_step();
  endtask

  // Monitor: every wr_req pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && spi_wr_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_wr_req: got pulse data %0h expected none (edge %0d)", spi_data, edge_n);
      end else begin
        x = exp_q.pop_front();
        check("spi_data", spi_data, x.word);
        check("wr_req_edge", edge_n, x.edge_no);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    model_reset();
    edge_n = 0; ack_mode = 0; fixed_k = 10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_req", spi_wr_req, 0);
    check("rst_spi_data", spi_data, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("spi_channel", spi_channel, 8'h01 << CSI);
    check("spi_cpol", spi_cpol, 0);
    check("spi_cpha", spi_cpha, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight after reset: A goes first.
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0);
    drain();
    // Single A frame.
    step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    // Coalescing: three codes while A waits for ack collapse to one frame.
    ack_mode = 2;
    step(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_step();
    idle_step();
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    ack_mode = 0;
    // Full-scale B with BUF and power-down bits set.
    cfg_buf = 1'b1; cfg_pd = 2'b11;
    step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    drain();
    cfg_buf = 1'b0; cfg_pd = 2'b00;
    // Timeout with clr_err on the setting edge (set wins), then a later clear.
    ack_mode = 1;
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_step();
    for (int i = 0; i < 40 && edge_n + 1 < to_edge; i++) idle_step();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    drain();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    idle_step();
    // Async reset while waiting for ack; a pending B code is lost.
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_step();
    idle_step();
    idle_step();
    step(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; spi_wr_ack = 1'b0; clr_err = 1'b0;
    #1;
    check("arst_wr_req", spi_wr_req, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_spi_data", spi_data, 16'h0000);
    check("arst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    ack_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle_step();
    step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random configuration, ack latency, timeouts and late acks.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_buf = 1'($urandom);
        cfg_pd = 2'($urandom);
        cfg_clk_div = 16'($urandom);
      end
      step($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 5) == 0, 8'($urandom),
           $urandom_range(0, 9) == 0, 1'b1);
    end
    drain();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_frame_cnt", frame_cnt, exp_frames);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
